axis_stream_master_gen: RTL
===========================

Name: axis_stream_master_gen

Overview:
- Parametrised, protocol-compliant AXI4-Stream master traffic generator; successor to the fixed 32-bit stream master template.
- Emits packets of configurable length, data width and payload pattern, with optional inter-packet gap and finite/infinite packet count.
- Feeds stream-sink DUTs and protocol checkers; TVALID/TDATA stability under backpressure is a hard requirement.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, data width in bits; multiple of 8, range 8..512.
- C_M_START_COUNT, 32, idle cycles after reset release before the first beat may be offered; 0 is legal.
- C_PKT_LEN, 8, beats per packet, >=1; TLAST marks beat C_PKT_LEN-1.
- C_NUM_PKTS, 0, packets to send before DONE; 0 means infinite.
- C_GAP_CYCLES, 0, idle cycles between the TLAST handshake and the next packet's first TVALID.
- C_MODE, 0, payload pattern: 0 = counter, 1 = byte-replicated counter.

Ports:
- M_AXIS_ACLK  in  1  clock; all logic on rising edge.
- M_AXIS_ARESETN  in  1  reset; asynchronous assert, active-low, synchronous release.
- EN  in  1  generation enable; sampled only at packet boundaries.
- M_AXIS_TREADY  in  1  sink ready.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  payload.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte strobes; all ones while TVALID=1, zero otherwise.
- M_AXIS_TLAST  out  1  last beat of packet.
- DONE  out  1  sticky; high once C_NUM_PKTS packets are complete.
- PKT_COUNT  out  32  number of completed packets; wraps at 2^32.

Behaviour:
Reset and timing:
- While M_AXIS_ARESETN=0: TVALID, TLAST, DONE and TSTRB are 0. TDATA, PKT_COUNT, beat counter and global beat index are 0. FSM is in WAIT_START.
- Reset asserted mid-packet: outputs clear immediately (asynchronous). No partial-packet recovery; after release the next packet restarts at beat 0 with global beat index 0.
- All outputs are registered; no combinational path from TREADY to any output.

Handshake:
- A beat transfers on a rising edge with TVALID=1 and TREADY=1.
- Once TVALID=1, TVALID, TDATA, TSTRB and TLAST hold unchanged until that handshake. EN changes do not affect a beat already offered.
- TVALID never depends on TREADY. The block must not wait for TREADY before asserting TVALID.

FSM (WAIT_START, SEND, GAP, DONE):
- WAIT_START: counts C_M_START_COUNT cycles. Then, if EN=1 (and not done), moves to SEND and asserts TVALID with beat 0 on the next edge. With C_M_START_COUNT=0 the move happens on the first edge after release if EN=1.
- SEND:
  - Each handshake advances the beat counter and presents the next beat on the following edge, so TVALID can stay high back-to-back: one beat per cycle at full throughput.
  - On the TLAST handshake: PKT_COUNT increments.
    - If PKT_COUNT reaches C_NUM_PKTS (nonzero), go to DONE.
    - Else if C_GAP_CYCLES>0, go to GAP.
    - Else, if EN=1, stay in SEND with beat 0 of the next packet offered on the next edge; if EN=0, go to WAIT_START with the start counter already expired.
- GAP: TVALID=0 for exactly C_GAP_CYCLES cycles, then the same EN check as above.
- DONE: TVALID=0 and DONE=1 until reset; EN is ignored.

Payload:
- The global beat index G increments on every handshake and does not reset between packets.
- Mode 0: TDATA = G zero-extended or truncated to C_M_AXIS_TDATA_WIDTH; wraps modulo 2^width.
- Mode 1: every byte lane = G[7:0].
- TLAST = (beat counter == C_PKT_LEN-1). When C_PKT_LEN=1, every beat has TLAST=1.

Simultaneous events:
- TLAST handshake in the same cycle EN falls: the packet completes and no new packet starts.
- EN rising during GAP is honoured at the end of GAP.

Decomposition:
- Package axis_gen_pkg holds the FSM state enum, the mode constants (MODE_COUNTER, MODE_BYTEREP) and the pattern-function helper.
- Optional sub-module axis_gen_pattern: combinational G -> TDATA mapping per mode, kept separate so new patterns can be added.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Defaults, EN=1, TREADY=1 constantly: first TVALID exactly 33 cycles after reset release; TDATA 0..7 on consecutive cycles; TLAST only with TDATA=7; next packet 8..15 follows with no bubble.
- Backpressure: TREADY toggles pseudo-randomly, including long-low stretches. Checker verifies TVALID never falls and TDATA/TLAST never change without a handshake; sequence stays gapless 0,1,2,...
- C_NUM_PKTS=2, C_GAP_CYCLES=3, TREADY=1: exactly 3 idle cycles between packets; after beat 15, DONE=1, PKT_COUNT=2, TVALID stays 0 for 50 further cycles.
- EN dropped at beat 3 of packet 0: beats 4..7 still delivered with TLAST on 7; no further TVALID. EN reasserted: packet resumes with TDATA=8.
- C_M_AXIS_TDATA_WIDTH=64, C_MODE=1, C_PKT_LEN=1: beats 0x0000000000000000, 0x0101010101010101, ...; every beat has TLAST=1 and TSTRB=0xFF.
- Reset asserted at beat 5 with TVALID=1 and TREADY=0: TVALID, TLAST, TSTRB and PKT_COUNT are 0 immediately. After release, the restart offers TDATA=0 after C_M_START_COUNT cycles.

Source files
------------

// File: rtl/axis_gen_pkg.sv
// Shared definitions for the AXI4-Stream master traffic generator.
// Provides the FSM state type, the payload mode constants and the per-lane
// pattern helper used by axis_gen_pattern.
package axis_gen_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_START = 2'd0,
        ST_SEND       = 2'd1,
        ST_GAP        = 2'd2,
        ST_DONE       = 2'd3
    } gen_state_t;

    localparam int MODE_COUNTER = 0;
    localparam int MODE_BYTEREP = 1;

    // One byte lane of the payload for global beat index g.
    // Counter mode: lane i carries byte i of g; lanes beyond g's 32 bits shift
    // out to zero, which gives the zero-extension for wide buses.
    // Byte-replicated mode: every lane carries g[7:0].
    function automatic logic [7:0] pattern_byte(input logic [31:0] g,
                                                input int          mode,
                                                input int          lane);
        logic [7:0] b;
        if (mode == MODE_BYTEREP) begin
            b = g[7:0];
        end else begin
            b = 8'(g >> (8 * lane));
        end
        return b;
    endfunction

endpackage

// File: rtl/axis_gen_pattern.sv
// Combinational mapping from the global beat index to the TDATA payload.
// Kept separate so further patterns only touch this file and the package.
// Ports:
//   g      in   32                    global beat index
//   tdata  out  C_M_AXIS_TDATA_WIDTH  payload word for that index
module axis_gen_pattern
    import axis_gen_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_MODE               = MODE_COUNTER
) (
    input  logic [31:0]                     g,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata
);

    localparam int NUM_LANES = C_M_AXIS_TDATA_WIDTH / 8;

    always_comb begin
        tdata = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            tdata[i*8 +: 8] = pattern_byte(g, C_MODE, i);
        end
    end

endmodule

// File: rtl/axis_stream_master_gen.sv
// AXI4-Stream master traffic generator: emits fixed-length packets with a
// configurable payload pattern, optional inter-packet gap and finite or
// infinite packet count. Every output is a flop; TREADY only feeds next-state
// logic, so an offered beat stays frozen until its handshake.
// Ports:
//   M_AXIS_ACLK     in   1        clock, rising edge
//   M_AXIS_ARESETN  in   1        async assert, active-low reset
//   EN              in   1        generation enable, sampled at packet boundaries
//   M_AXIS_TREADY   in   1        sink ready
//   M_AXIS_TVALID   out  1        beat valid
//   M_AXIS_TDATA    out  W        payload
//   M_AXIS_TSTRB    out  W/8      all ones while TVALID, else zero
//   M_AXIS_TLAST    out  1        last beat of packet
//   DONE            out  1        sticky, set after C_NUM_PKTS packets
//   PKT_COUNT       out  32       completed packets, wrapping
//
// state          | meaning
// ST_WAIT_START  | start delay running, or idle waiting for EN
// ST_SEND        | beat offered on the bus (TVALID=1)
// ST_GAP         | inter-packet idle, C_GAP_CYCLES long
// ST_DONE        | packet budget exhausted, idle until reset
module axis_stream_master_gen
    import axis_gen_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_M_START_COUNT      = 32,
    parameter int C_PKT_LEN            = 8,
    parameter int C_NUM_PKTS           = 0,
    parameter int C_GAP_CYCLES         = 0,
    parameter int C_MODE               = MODE_COUNTER
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              EN,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    output logic                              DONE,
    output logic [31:0]                       PKT_COUNT
);

    localparam int          STRB_W     = C_M_AXIS_TDATA_WIDTH / 8;
    localparam logic [31:0] START_LD   = 32'(C_M_START_COUNT);
    // Gap counter terminates at zero, so it is loaded with one less than the gap.
    localparam logic [31:0] GAP_LD     = (C_GAP_CYCLES > 0) ? 32'(C_GAP_CYCLES - 1) : 32'd0;
    localparam logic [31:0] LAST_BEAT  = 32'(C_PKT_LEN - 1);
    localparam logic [31:0] NUM_PKTS_W = 32'(C_NUM_PKTS);
    localparam bit          FINITE     = (C_NUM_PKTS != 0);
    localparam bit          HAS_GAP    = (C_GAP_CYCLES > 0);

    gen_state_t state_q, state_d;

    logic [31:0] start_cnt_q, start_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] beat_q, beat_d;
    logic [31:0] g_q, g_d;
    logic [31:0] pkt_count_q, pkt_count_d;

    logic                            tvalid_q, tlast_q, done_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q, pattern_d;
    logic [STRB_W-1:0]               tstrb_q;

    logic hs, last_hs, tvalid_d, tlast_d;

    axis_gen_pattern #(
        .C_M_AXIS_TDATA_WIDTH (C_M_AXIS_TDATA_WIDTH),
        .C_MODE               (C_MODE)
    ) u_pattern (
        .g     (g_d),
        .tdata (pattern_d)
    );

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q <= ST_WAIT_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        hs          = tvalid_q & M_AXIS_TREADY;
        last_hs     = hs & tlast_q;
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        g_d         = g_q + {31'd0, hs};
        pkt_count_d = pkt_count_q + {31'd0, last_hs};
        beat_d      = beat_q;
        if (hs) begin
            beat_d = tlast_q ? 32'd0 : beat_q + 32'd1;
        end

        case (state_q)
            ST_WAIT_START: begin
                // The start counter is only loaded by reset, so returning here
                // after an EN drop waits for EN alone.
                if (start_cnt_q != 32'd0) begin
                    start_cnt_d = start_cnt_q - 32'd1;
                end else if (EN) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_hs) begin
                    if (FINITE && (pkt_count_d == NUM_PKTS_W)) begin
                        state_d = ST_DONE;
                    end else if (HAS_GAP) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LD;
                    end else if (!EN) begin
                        state_d = ST_WAIT_START;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != 32'd0) begin
                    gap_cnt_d = gap_cnt_q - 32'd1;
                end else if (EN) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_WAIT_START;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_WAIT_START;
            end
        endcase

        tvalid_d = (state_d == ST_SEND);
        tlast_d  = tvalid_d && (beat_d == LAST_BEAT);
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            start_cnt_q <= START_LD;
            gap_cnt_q   <= 32'd0;
            beat_q      <= 32'd0;
            g_q         <= 32'd0;
            pkt_count_q <= 32'd0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tstrb_q     <= '0;
            tdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            start_cnt_q <= start_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            beat_q      <= beat_d;
            g_q         <= g_d;
            pkt_count_q <= pkt_count_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tstrb_q     <= {STRB_W{tvalid_d}};
            // Without a handshake g_d equals g_q, so the offered word is held.
            tdata_q     <= pattern_d;
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TSTRB  = tstrb_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign DONE          = done_q;
    assign PKT_COUNT     = pkt_count_q;

endmodule
